// File: rtl/sec_timer_ctrl.sv
// Period timer with up/down 4-bit count, pause/resume and clear.
// Define SEC_TIMER_CTRL_AUTORELOAD_EN to reload on terminal instead of stopping.
module sec_timer_ctrl #(
  parameter int unsigned SEC1_MAX = 50000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       STOP,
  input  logic       CLEAR,
  input  logic       DIR,
  input  logic [3:0] LIMIT,
  output logic [3:0] COUNT,
  output logic       TICK,
  output logic       BUSY,
  output logic       DONE,
  output logic       WRAP
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [25:0] PMAX = 26'(SEC1_MAX - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic [25:0] presc_q, presc_d;
  logic        dir_q, dir_d;
  logic [3:0]  limit_q, limit_d;
  logic        tick_q, tick_d;
  logic        wrap_q, wrap_d;

  logic [3:0] new_s, new_t, t_val, step;
`ifdef SEC_TIMER_CTRL_AUTORELOAD_EN
  logic [3:0] s_val;
  assign s_val = dir_q ? limit_q : 4'd0;
`endif

  assign new_s = DIR ? LIMIT : 4'd0;
  assign new_t = DIR ? 4'd0 : LIMIT;
  assign t_val = dir_q ? 4'd0 : limit_q;
  assign step  = dir_q ? count_q - 4'd1 : count_q + 4'd1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    limit_d = limit_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (CLEAR) begin
      state_d = ST_IDLE;
      count_d = 4'd0;
      presc_d = 26'd0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (START && !STOP) begin
            dir_d   = DIR;
            limit_d = LIMIT;
            count_d = new_s;
            presc_d = 26'd0;
            state_d = ST_RUN;
`ifndef SEC_TIMER_CTRL_AUTORELOAD_EN
            if (new_s == new_t) state_d = ST_DONE;
`endif
          end
        end
        ST_RUN: begin
          // a coinciding STOP swallows the period event
          if (STOP) begin
            state_d = ST_PAUSE;
          end else if (presc_q == PMAX) begin
            presc_d = 26'd0;
            tick_d  = 1'b1;
`ifdef SEC_TIMER_CTRL_AUTORELOAD_EN
            if (count_q == t_val) begin
              count_d = s_val;
              wrap_d  = 1'b1;
            end else begin
              count_d = step;
            end
`else
            count_d = step;
            if (step == t_val) state_d = ST_DONE;
`endif
          end else begin
            presc_d = presc_q + 26'd1;
          end
        end
        ST_PAUSE: begin
          if (START && !STOP) state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      count_q <= 4'd0;
      presc_q <= 26'd0;
      dir_q   <= 1'b0;
      limit_q <= 4'd0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      dir_q   <= dir_d;
      limit_q <= limit_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign COUNT = count_q;
  assign TICK  = tick_q;
  assign BUSY  = (state_q == ST_RUN);
  assign DONE  = (state_q == ST_DONE);
`ifdef SEC_TIMER_CTRL_AUTORELOAD_EN
  assign WRAP  = wrap_q;
`else
  assign WRAP  = 1'b0;
  logic unused_wrap;
  assign unused_wrap = wrap_q;
`endif

endmodule

// File: tb/tb_sec_timer_ctrl.sv
// Bench for sec_timer_ctrl: directed scenarios plus random commands
// checked each cycle against a behavioural model.
module tb_sec_timer_ctrl;

  localparam int P = 4;

  logic       CLK = 1'b0;
  logic       RESET, START, STOP, CLEAR, DIR;
  logic [3:0] LIMIT;
  logic [3:0] COUNT;
  logic       TICK, BUSY, DONE, WRAP;

  sec_timer_ctrl #(.SEC1_MAX(P)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP),
    .CLEAR(CLEAR), .DIR(DIR), .LIMIT(LIMIT), .COUNT(COUNT),
    .TICK(TICK), .BUSY(BUSY), .DONE(DONE), .WRAP(WRAP)
  );

  always #5 CLK = ~CLK;

  int n_run = 0;
  int n_fail = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t m_mode;
  int m_cnt, m_elapsed, m_dir, m_lim;
  bit m_tick, m_wrap;

  function automatic int term_of(int d, int l);
    return d ? 0 : l;
  endfunction

  task automatic model(input bit r, s, p, c, d, input int l);
    int nxt;
    m_tick = 0;
    m_wrap = 0;
    if (r || c) begin
      m_mode = M_IDLE;
      m_cnt = 0;
      m_elapsed = 0;
      if (r) begin
        m_dir = 0;
        m_lim = 0;
      end
    end else if (m_mode == M_IDLE || m_mode == M_DONE) begin
      if (s && !p) begin
        m_dir = d;
        m_lim = l;
        m_cnt = d ? l : 0;
        m_elapsed = 0;
        m_mode = M_RUN;
`ifndef SEC_TIMER_CTRL_AUTORELOAD_EN
        if (m_cnt == term_of(d, l)) m_mode = M_DONE;
`endif
      end
    end else if (m_mode == M_PAUSE) begin
      if (s && !p) m_mode = M_RUN;
    end else if (p) begin
      m_mode = M_PAUSE;
    end else if (m_elapsed + 1 == P) begin
      m_elapsed = 0;
      m_tick = 1;
      nxt = (m_cnt + (m_dir ? 15 : 1)) % 16;
`ifdef SEC_TIMER_CTRL_AUTORELOAD_EN
      if (m_cnt == term_of(m_dir, m_lim)) begin
        m_wrap = 1;
        nxt = m_dir ? m_lim : 0;
      end
      m_cnt = nxt;
`else
      m_cnt = nxt;
      if (nxt == term_of(m_dir, m_lim)) m_mode = M_DONE;
`endif
    end else begin
      m_elapsed++;
    end
  endtask

  task automatic cyc(input bit r, s, p, c, d, input int l);
    RESET = r; START = s; STOP = p; CLEAR = c; DIR = d;
    LIMIT = 4'(l);
    @(posedge CLK);
    model(r, s, p, c, d, l);
    #1;
    check("count", int'(COUNT), m_cnt);
    check("tick", int'(TICK), int'(m_tick));
    check("busy", int'(BUSY), int'(m_mode == M_RUN));
    check("done", int'(DONE), int'(m_mode == M_DONE));
    check("wrap", int'(WRAP), int'(m_wrap));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  int ticks;

  initial begin
    m_mode = M_IDLE;
    m_cnt = 0; m_elapsed = 0; m_dir = 0; m_lim = 0;
    cyc(1, 0, 0, 0, 0, 0);
    check("rst_count", int'(COUNT), 0);
    check("rst_busy", int'(BUSY), 0);
    idle(2);

`ifndef SEC_TIMER_CTRL_AUTORELOAD_EN
    cyc(0, 1, 0, 0, 0, 3);
    check("up_start_busy", int'(BUSY), 1);
    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (TICK) ticks++;
      if (i == 3) check("up_first", int'(COUNT), 1);
      if (i == 7) check("up_second", int'(COUNT), 2);
    end
    check("up_ticks", ticks, 3);
    check("up_done", int'(DONE), 1);
    check("up_final", int'(COUNT), 3);

    cyc(0, 1, 0, 0, 1, 2);
    check("dn_start", int'(COUNT), 2);
    idle(12);
    check("dn_done", int'(DONE), 1);
    check("dn_final", int'(COUNT), 0);
    cyc(0, 1, 0, 0, 1, 2);
    check("restart_cnt", int'(COUNT), 2);
    check("restart_busy", int'(BUSY), 1);

    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 1, 0, 0, 0, 9);
    idle(6);
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      check("pause_hold", int'(COUNT), 1);
    end
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("resume_early", int'(COUNT), 1);
    cyc(0, 0, 0, 0, 0, 0);
    check("resume_cnt", int'(COUNT), 2);
    check("resume_tick", int'(TICK), 1);

    cyc(0, 1, 0, 1, 0, 5);
    check("clr_cnt", int'(COUNT), 0);
    check("clr_busy", int'(BUSY), 0);
    cyc(0, 1, 0, 0, 1, 7);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    check("rst_pause", int'({COUNT, TICK, BUSY, DONE, WRAP}), 0);

    cyc(0, 1, 0, 0, 0, 0);
    check("zero_done", int'(DONE), 1);
    check("zero_cnt", int'(COUNT), 0);
    check("zero_tick", int'(TICK), 0);
`else
    cyc(0, 1, 0, 0, 0, 1);
    ticks = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (WRAP) ticks++;
      check("ar_never_done", int'(DONE), 0);
    end
    check("ar_wraps", ticks, 3);
`endif

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      cyc(r == 0, r >= 1 && r < 9, r >= 9 && r < 13,
          r >= 13 && r < 15, 1'($urandom), int'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sec_timer_ctrl.md
SEC_TIMER_CTRL -- requirements
Module: sec_timer_ctrl

Interface
REQ-001 SHALL have parameter SEC1_MAX, default 50000000, meaning clock cycles per count period (range 1..2^26).
REQ-002 SHALL have port CLK  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port RESET  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port START  input  1  single-cycle command: start or resume.
REQ-005 SHALL have port STOP  input  1  single-cycle command: pause.
REQ-006 SHALL have port CLEAR  input  1  single-cycle command: abort to IDLE.
REQ-007 SHALL have port DIR  input  1  0 = count up, 1 = count down; sampled on START from IDLE or DONE.
REQ-008 SHALL have port LIMIT  input  4  terminal/start value; sampled on START from IDLE or DONE.
REQ-009 SHALL have port COUNT  output  4  registered current count.
REQ-010 SHALL have port TICK  output  1  one-cycle pulse, high in the cycle the new COUNT is first visible.
REQ-011 SHALL have port BUSY  output  1  high while in RUN.
REQ-012 SHALL have port DONE  output  1  high while in DONE.
REQ-013 SHALL have port WRAP  output  1  one-cycle pulse on auto-reload (see Configuration).

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-015 SHALL contain a 26-bit prescaler that increments only in RUN; at SEC1_MAX-1 it returns to 0 and produces a period event.
REQ-016 SHALL define start value S = 0 (DIR=0) or latched LIMIT (DIR=1), and terminal T = latched LIMIT (DIR=0) or 0 (DIR=1).
REQ-017 SHALL on START in IDLE or DONE: latch DIR/LIMIT, COUNT <= S, prescaler <= 0, enter RUN next cycle; if S == T and macro absent, enter DONE instead.
REQ-018 SHALL on period event in RUN: COUNT <= COUNT+1 (up) or COUNT-1 (down), TICK high next cycle; if new COUNT == T and macro absent, enter DONE.
REQ-019 SHALL on STOP in RUN enter PAUSE, holding COUNT and prescaler; START in PAUSE returns to RUN with prescaler retained (no re-latch of DIR/LIMIT).
REQ-020 SHALL on CLEAR in any state enter IDLE, COUNT <= 0, prescaler <= 0.
REQ-021 SHALL apply command priority CLEAR > STOP > START when asserted in the same cycle.
REQ-022 SHALL ignore START in RUN, STOP in IDLE/PAUSE/DONE, and DIR/LIMIT changes outside REQ-017.
REQ-023 SHALL hold COUNT unchanged in IDLE, PAUSE and DONE.
REQ-024 SHALL suppress a period event coinciding with STOP or CLEAR (command wins; no COUNT change, no TICK).

Reset
REQ-025 SHALL on RESET high at a rising CLK edge: state IDLE, COUNT 0, prescaler 0, TICK 0, BUSY 0, DONE 0, WRAP 0.
REQ-026 SHALL give RESET priority over all commands, including mid-RUN and mid-PAUSE.

Configuration
REQ-027 SHALL support macro SEC_TIMER_CTRL_AUTORELOAD_EN.
REQ-028 SHALL, with macro defined, never enter DONE from RUN: period event with COUNT == T reloads COUNT <= S, TICK and WRAP pulse together; S == T (LIMIT=0) keeps COUNT at 0 with WRAP every period.
REQ-029 SHALL, with macro undefined, follow REQ-017/REQ-018 terminal behaviour and tie WRAP to 0.

Verification (SEC1_MAX = 4)
REQ-030 SHALL cover: RESET, START with DIR=0 LIMIT=3 -> COUNT 1,2,3 at 4-cycle spacing, TICK each step, DONE=1 with COUNT=3 (macro off).
REQ-031 SHALL cover: START DIR=1 LIMIT=2 -> COUNT 2,1,0 then DONE; START again from DONE -> COUNT 2, BUSY=1.
REQ-032 SHALL cover: STOP 2 cycles into a period, hold 10 cycles, START -> next increment 2 cycles after resume, COUNT unchanged during PAUSE.
REQ-033 SHALL cover: CLEAR and START same cycle in RUN -> IDLE, COUNT=0, BUSY=0; RESET asserted in PAUSE -> all outputs 0 next cycle.
REQ-034 SHALL cover: macro on, DIR=0 LIMIT=1 -> COUNT 1,0,1,0..., WRAP with each 1->0 step, DONE never 1.
REQ-035 SHALL cover: LIMIT=0 DIR=0 START -> DONE next cycle, COUNT=0, no TICK (macro off).
